// File: rtl/mbisr_repair_register_multi.sv
// ---------------------------------------------------------------------------
// mbisr_repair_register_multi
//
// Repair register for one repairable memory. It holds NUM_ENTRIES repair
// solutions of WIDTH bits each. Bit WIDTH-1 of each entry is its
// valid/repair-enable bit.
//
// Repairs arriving from BIRA are handled as follows:
//   - a repair identical to a valid entry is dropped as a duplicate;
//   - otherwise it goes into the lowest-index free entry;
//   - if no entry is free, the sticky OVERFLOW flag is set.
//
// The register is part of the BISR scan chain, LSB first:
//   [PAR,] OVF, E[0][0] .. E[NUM_ENTRIES-1][WIDTH-1]
// SO is retimed on the falling clock edge. MSEL selects the memory-side
// scan-out MSO onto SO as a bypass.
//
// Optional feature: define MBISR_REPAIR_PARITY_EN to enable it. This adds a
// parity flop as chain bit 0 and adds the PARITY_ERR output.
//
// Ports:
//   CLK, RSTB    clock, asynchronous active-low reset
//   SI, SO       scan-in / retimed scan-out
//   SE           shift enable (highest priority)
//   CLR          synchronous clear of all entries and OVERFLOW
//   D, D_VALID   repair solution from BIRA
//   MSO, MSEL    scan-out bypass input and its select
//   Q            entry i on Q[i*WIDTH +: WIDTH]
//   FULL         all entries valid
//   OVERFLOW     sticky: a repair was lost for lack of a free entry
//   PARITY_ERR   (parity build only) stored parity disagrees with entries
// ---------------------------------------------------------------------------
module mbisr_repair_register_multi #(
   parameter int WIDTH       = 26,
   parameter int NUM_ENTRIES = 2
) (
   input  logic                         CLK,
   input  logic                         RSTB,
   input  logic                         SI,
   output logic                         SO,
   input  logic                         SE,
   input  logic                         CLR,
   input  logic [WIDTH-1:0]             D,
   input  logic                         D_VALID,
   input  logic                         MSO,
   input  logic                         MSEL,
   output logic [NUM_ENTRIES*WIDTH-1:0] Q,
   output logic                         FULL,
`ifdef MBISR_REPAIR_PARITY_EN
   output logic                         PARITY_ERR,
`endif
   output logic                         OVERFLOW
);

   localparam int EW = NUM_ENTRIES * WIDTH;
`ifdef MBISR_REPAIR_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int CL = EW + 1 + PB;

   // All state lives in one vector laid out in chain order, so a shift is
   // a single concatenation.
   logic [CL-1:0]          chain_q;
   logic [CL-1:0]          chain_d;
   logic                   so_q;
   logic [EW-1:0]          entries_s;
   logic [EW-1:0]          entries_wr_s;
   logic [NUM_ENTRIES-1:0] valid_s;
   logic                   ovf_s;
   logic                   dup_s;
   logic                   free_s;

`ifdef MBISR_REPAIR_PARITY_EN
   function automatic logic xor_bits(input logic [EW-1:0] v);
      return ^v;
   endfunction
`endif

   assign entries_s = chain_q[CL-1 -: EW];
   assign ovf_s     = chain_q[PB];

   // Per-entry valid bits, duplicate detection, and the first-free write image.
   always_comb begin
      valid_s      = {NUM_ENTRIES{1'b0}};
      dup_s        = 1'b0;
      free_s       = 1'b0;
      entries_wr_s = entries_s;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         valid_s[i] = entries_s[i*WIDTH + WIDTH - 1];
         if (valid_s[i]) begin
            if (entries_s[i*WIDTH +: WIDTH] == D) begin
               dup_s = 1'b1;
            end else begin
               dup_s = dup_s;
            end
         end else if (!free_s) begin
            // Only the lowest free entry receives D.
            free_s = 1'b1;
            entries_wr_s[i*WIDTH +: WIDTH] = D;
         end else begin
            free_s = free_s;
         end
      end
   end

   // Next state. Priority is shift, then clear, then allocation, then hold.
   always_comb begin
      chain_d = chain_q;
      if (SE) begin
         chain_d = {SI, chain_q[CL-1:1]};
      end else if (CLR) begin
         // Parity of all-zero entries is zero, so PAR is cleared too.
         chain_d = {CL{1'b0}};
      end else if (D_VALID && D[WIDTH-1] && !dup_s) begin
         if (free_s) begin
            chain_d[CL-1 -: EW] = entries_wr_s;
`ifdef MBISR_REPAIR_PARITY_EN
            chain_d[0] = xor_bits(entries_wr_s);
`endif
         end else begin
            chain_d[PB] = 1'b1;
         end
      end else begin
         chain_d = chain_q;
      end
   end

   // Entry, overflow (and parity) state.
   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         chain_q <= {CL{1'b0}};
      end else begin
         chain_q <= chain_d;
      end
   end

   // Falling-edge retime of scan-out gives the next segment half a cycle of hold.
   always_ff @(negedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         so_q <= 1'b0;
      end else begin
         so_q <= MSEL ? MSO : chain_q[0];
      end
   end

   assign SO       = so_q;
   assign Q        = entries_s;
   assign FULL     = &valid_s;
   assign OVERFLOW = ovf_s;
`ifdef MBISR_REPAIR_PARITY_EN
   assign PARITY_ERR = SE ? 1'b0 : (xor_bits(entries_s) ^ chain_q[0]);
`endif

endmodule

// File: tb/tb_mbisr_repair_register_multi.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for mbisr_repair_register_multi.
// It uses WIDTH=26 and NUM_ENTRIES=2.
// ---------------------------------------------------------------------------
module tb_mbisr_repair_register_multi;

`ifdef MBISR_REPAIR_PARITY_EN
   localparam int L = 54;
`else
   localparam int L = 53;
`endif

   logic        CLK = 1'b0;
   logic        RSTB, SI, SE, CLR, D_VALID, MSO, MSEL;
   logic [25:0] D;
   logic        SO, FULL, OVERFLOW;
   logic [51:0] Q;
`ifdef MBISR_REPAIR_PARITY_EN
   logic        PARITY_ERR;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] pat;

   mbisr_repair_register_multi #(.WIDTH(26), .NUM_ENTRIES(2)) dut (
      .CLK(CLK), .RSTB(RSTB), .SI(SI), .SO(SO), .SE(SE), .CLR(CLR),
      .D(D), .D_VALID(D_VALID), .MSO(MSO), .MSEL(MSEL), .Q(Q), .FULL(FULL),
`ifdef MBISR_REPAIR_PARITY_EN
      .PARITY_ERR(PARITY_ERR),
`endif
      .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Chain image, bit 0 first out: [PAR,] OVF, E0, E1.
   function automatic logic [63:0] mk_chain(input logic [25:0] e1, input logic [25:0] e0,
                                            input logic ovf);
      logic [63:0] c;
      c = 64'd0;
`ifdef MBISR_REPAIR_PARITY_EN
      c[53:0] = {e1, e0, ovf, ^{e1, e0}};
`else
      c[52:0] = {e1, e0, ovf};
`endif
      return c;
   endfunction

   // Shift L cycles, feeding si_bits LSB first and checking SO against so_bits.
   task automatic shift_chain(input logic [63:0] si_bits, input logic [63:0] so_bits);
      SE = 1'b1;
      for (int k = 0; k < L; k++) begin
         SI = si_bits[k];
         @(negedge CLK);
         #1;
         chk($sformatf("so_bit%0d", k), {63'd0, SO}, {63'd0, so_bits[k]});
         step();
      end
      SE = 1'b0;
      SI = 1'b0;
   endtask

   initial begin
      RSTB = 1'b0; SI = 1'b0; SE = 1'b0; CLR = 1'b0; D_VALID = 1'b0;
      MSO = 1'b0; MSEL = 1'b0; D = 26'd0;
      step();
      step();
      chk("rst_q", {12'd0, Q}, 64'd0);
      chk("rst_full", {63'd0, FULL}, 64'd0);
      chk("rst_ovf", {63'd0, OVERFLOW}, 64'd0);
      chk("rst_so", {63'd0, SO}, 64'd0);
      RSTB = 1'b1;
      step();

      // Read back the reset contents: all zeros.
      shift_chain(64'd0, 64'd0);
      chk("read_q", {12'd0, Q}, 64'd0);
      chk("read_full", {63'd0, FULL}, 64'd0);

      // Allocation with a duplicate in the middle.
      D_VALID = 1'b1; D = 26'h2000005;
      step();
      chk("alloc0_q", {12'd0, Q}, {12'd0, 26'h0000000, 26'h2000005});
      step();
      chk("dup_q", {12'd0, Q}, {12'd0, 26'h0000000, 26'h2000005});
      D = 26'h20000A0;
      step();
      chk("alloc1_q", {12'd0, Q}, {12'd0, 26'h20000A0, 26'h2000005});
      chk("alloc1_full", {63'd0, FULL}, 64'd1);
      chk("alloc1_ovf", {63'd0, OVERFLOW}, 64'd0);

      // Full register: the new repair is lost and OVERFLOW is set.
      D = 26'h2000111;
      step();
      chk("ovf_flag", {63'd0, OVERFLOW}, 64'd1);
      chk("ovf_q", {12'd0, Q}, {12'd0, 26'h20000A0, 26'h2000005});

      // CLR beats D_VALID.
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      chk("clr_q", {12'd0, Q}, 64'd0);
      chk("clr_ovf", {63'd0, OVERFLOW}, 64'd0);
      chk("clr_full", {63'd0, FULL}, 64'd0);

      // A repair with its valid bit at 0 is ignored.
      D = 26'h0000111;
      step();
      D_VALID = 1'b0;
      chk("inval_q", {12'd0, Q}, 64'd0);

      // Load a pattern by shifting. CLR and D_VALID are held high throughout and must be ignored.
      pat = mk_chain(26'h1555555, 26'h3FFFFFF, 1'b1);
      CLR = 1'b1; D_VALID = 1'b1; D = 26'h2000111;
      shift_chain(pat, 64'd0);
      CLR = 1'b0; D_VALID = 1'b0;
      chk("load_q", {12'd0, Q}, {12'd0, 26'h1555555, 26'h3FFFFFF});
      chk("load_ovf", {63'd0, OVERFLOW}, 64'd1);
      chk("load_full", {63'd0, FULL}, 64'd0);

      // A duplicate of E0 is dropped.
      D_VALID = 1'b1; D = 26'h3FFFFFF;
      step();
      chk("dup2_q", {12'd0, Q}, {12'd0, 26'h1555555, 26'h3FFFFFF});

      // The next repair skips valid E0 and fills E1. OVERFLOW stays set.
      D = 26'h2000222;
      step();
      D_VALID = 1'b0;
      chk("gap_q", {12'd0, Q}, {12'd0, 26'h2000222, 26'h3FFFFFF});
      chk("gap_full", {63'd0, FULL}, 64'd1);
      chk("gap_ovf", {63'd0, OVERFLOW}, 64'd1);

      // Shift the contents out and check them bit by bit.
      shift_chain(64'd0, mk_chain(26'h2000222, 26'h3FFFFFF, 1'b1));
      chk("out_q", {12'd0, Q}, 64'd0);
      chk("out_ovf", {63'd0, OVERFLOW}, 64'd0);

      // Bypass: SO follows MSO while the chain keeps shifting SI.
      pat = mk_chain(26'h2ABCDEF, 26'h1234567, 1'b0);
      MSEL = 1'b1; SE = 1'b1;
      for (int k = 0; k < L; k++) begin
         SI  = pat[k];
         MSO = (k % 2 == 1);
         @(negedge CLK);
         #1;
         chk($sformatf("mso_%0d", k), {63'd0, SO}, {63'd0, MSO});
         step();
      end
      MSEL = 1'b0; SE = 1'b0; SI = 1'b0; MSO = 1'b0;
      chk("byp_q", {12'd0, Q}, {12'd0, 26'h2ABCDEF, 26'h1234567});
      chk("byp_ovf", {63'd0, OVERFLOW}, 64'd0);
      chk("byp_full", {63'd0, FULL}, 64'd0);
      @(negedge CLK);
      #1;
      chk("byp_so_off", {63'd0, SO}, {63'd0, pat[0]});
      step();

      // Reset asserted at cycle 20 of a shift clears everything at once.
      SE = 1'b1; SI = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
      end
      RSTB = 1'b0;
      #1;
      chk("mrst_q", {12'd0, Q}, 64'd0);
      chk("mrst_ovf", {63'd0, OVERFLOW}, 64'd0);
      chk("mrst_so", {63'd0, SO}, 64'd0);
      step();
      RSTB = 1'b1; SE = 1'b0; SI = 1'b0;
      step();
      chk("mrst_after_q", {12'd0, Q}, 64'd0);
      chk("mrst_after_full", {63'd0, FULL}, 64'd0);

`ifdef MBISR_REPAIR_PARITY_EN
      // Flip one bit by shifting: a parity error is flagged only once SE drops.
      chk("par_clean", {63'd0, PARITY_ERR}, 64'd0);
      SE = 1'b1; SI = 1'b1;
      step();
      chk("par_masked", {63'd0, PARITY_ERR}, 64'd0);
      SE = 1'b0; SI = 1'b0;
      #1;
      chk("par_err", {63'd0, PARITY_ERR}, 64'd1);
      D_VALID = 1'b1; D = 26'h2000001;
      step();
      D_VALID = 1'b0;
      chk("par_q", {12'd0, Q}, {12'd0, 26'h2000000, 26'h2000001});
      chk("par_fixed", {63'd0, PARITY_ERR}, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
